// File: rtl/rvfi_check_sequencer_if.sv
// Bundles the start request, RVFI retirement bus and sequencer status into one port.
interface rvfi_check_sequencer_if #(
  parameter int NRET    = 1,
  parameter int ORDER_W = 64,
  parameter int CH_W    = 1,
  parameter int CNT_W   = 16
);
  logic                    start;
  logic [ORDER_W-1:0]      target_order;
  logic [NRET-1:0]         rvfi_valid;
  logic [NRET*ORDER_W-1:0] rvfi_order;
  logic                    check;
  logic [CH_W-1:0]         check_channel;
  logic                    busy;
  logic                    done;
  logic                    timed_out;
  logic                    err;
  logic [CNT_W-1:0]        retire_count;

  modport master (
    output start, target_order, rvfi_valid, rvfi_order,
    input  check, check_channel, busy, done, timed_out, err, retire_count
  );

  modport slave (
    input  start, target_order, rvfi_valid, rvfi_order,
    output check, check_channel, busy, done, timed_out, err, retire_count
  );
endinterface

// File: rtl/rvfi_check_sequencer.sv
// Arms on a target instruction order and pulses check in the exact cycle that order
// retires on any RVFI channel; tracks completion, timeout and duplicate-retire errors.
module rvfi_check_sequencer #(
  parameter int NRET    = 1,
  parameter int ORDER_W = 64,
  parameter int CH_W    = 1,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  rvfi_check_sequencer_if.slave  bus
);
  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE, S_TMO} state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [ORDER_W-1:0] r_tgt;
  logic [TMR_W-1:0]   r_timer;
  logic [CNT_W-1:0]   r_retire_count;
  logic               r_done;
  logic               r_timed_out;
  logic               r_err;

  logic [NRET-1:0]    w_hit;
  logic               w_any_hit;
  logic               w_multi_hit;
  logic [CH_W-1:0]    w_lowest;
  logic [CNT_W:0]     w_pop;
  logic [CNT_W:0]     w_sum;
  logic [CNT_W-1:0]   w_count_sat;
  logic               w_timer_last;
  logic               w_arm;
  logic               w_check;
  logic [CH_W-1:0]    w_check_channel;

  for (genvar gi = 0; gi < NRET; gi++) begin : g_hit
    assign w_hit[gi] = bus.rvfi_valid[gi] &&
                       (bus.rvfi_order[ORDER_W*gi +: ORDER_W] == r_tgt);
  end

  assign w_any_hit   = |w_hit;
  // Clearing the lowest set bit leaves something only if two or more bits were set.
  assign w_multi_hit = |(w_hit & (w_hit - NRET'(1)));

  always_comb begin
    w_lowest = '0;
    for (int i = NRET - 1; i >= 0; i--) begin
      if (w_hit[i]) w_lowest = CH_W'(i);
    end
  end

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < NRET; i++) begin
      w_pop = w_pop + (CNT_W+1)'(bus.rvfi_valid[i]);
    end
  end

  assign w_sum        = {1'b0, r_retire_count} + w_pop;
  assign w_count_sat  = w_sum[CNT_W] ? '1 : w_sum[CNT_W-1:0];
  assign w_timer_last = (r_timer == TMR_W'(TIMEOUT - 1));
  assign w_arm        = bus.start && (r_state != S_WAIT);

  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next    = r_state;
    w_check         = 1'b0;
    w_check_channel = '0;
    case (r_state)
      S_WAIT: begin
        // A hit in the final timer cycle still counts as completion.
        if (w_any_hit) begin
          w_check         = 1'b1;
          w_check_channel = w_lowest;
          w_state_next    = S_DONE;
        end else if (w_timer_last) begin
          w_state_next = S_TMO;
        end
      end
      default: begin
        if (bus.start) w_state_next = S_WAIT;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_tgt          <= '0;
      r_timer        <= '0;
      r_retire_count <= '0;
      r_done         <= 1'b0;
      r_timed_out    <= 1'b0;
      r_err          <= 1'b0;
    end else if (w_arm) begin
      r_tgt          <= bus.target_order;
      r_timer        <= '0;
      r_retire_count <= '0;
      r_done         <= 1'b0;
      r_timed_out    <= 1'b0;
      r_err          <= 1'b0;
    end else begin
      if (r_state == S_WAIT) begin
        r_retire_count <= w_count_sat;
        if (w_any_hit) begin
          r_done <= 1'b1;
          if (w_multi_hit) r_err <= 1'b1;
        end else if (w_timer_last) begin
          r_timed_out <= 1'b1;
        end else begin
          r_timer <= r_timer + TMR_W'(1);
        end
      end
      if ((r_state == S_DONE) && w_any_hit) r_err <= 1'b1;
    end
  end

  assign bus.check         = w_check;
  assign bus.check_channel = w_check_channel;
  assign bus.busy          = (r_state == S_WAIT);
  assign bus.done          = r_done;
  assign bus.timed_out     = r_timed_out;
  assign bus.err           = r_err;
  assign bus.retire_count  = r_retire_count;
endmodule

// File: tb/tb_rvfi_check_sequencer.sv
// Directed bench: one single-channel instance with a short timeout and one dual-channel
// instance with a long timeout, each step pushing its expected outputs to a scoreboard.
module tb_rvfi_check_sequencer;
  logic clock;
  logic reset;

  typedef struct {
    string       tag;
    logic [63:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  rvfi_check_sequencer_if #(.NRET(1), .ORDER_W(64), .CH_W(1), .CNT_W(16)) bus1 ();
  rvfi_check_sequencer_if #(.NRET(2), .ORDER_W(64), .CH_W(1), .CNT_W(16)) bus2 ();

  rvfi_check_sequencer #(
    .NRET(1), .ORDER_W(64), .CH_W(1), .TIMEOUT(4), .CNT_W(16)
  ) u_dut1 (
    .clock (clock),
    .reset (reset),
    .bus   (bus1)
  );

  rvfi_check_sequencer #(
    .NRET(2), .ORDER_W(64), .CH_W(1), .TIMEOUT(40000), .CNT_W(16)
  ) u_dut2 (
    .clock (clock),
    .reset (reset),
    .bus   (bus2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic push(input string tag, input logic [63:0] exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic observe(input logic [63:0] obs);
    exp_t e;
    n_checks++;
    if (sb_q.size() == 0) begin
      n_errors++;
      $error("FAIL sb_underflow: observed=%0h expected=none", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.exp) else begin
        n_errors++;
        $error("FAIL %s: observed=%0h expected=%0h", e.tag, obs, e.exp);
      end
    end
  endtask

  // One clock cycle on the single-channel instance; expectations describe this cycle.
  task automatic step1(input logic st, input logic [63:0] tg, input logic v,
                       input logic [63:0] od, input logic ec, input logic ech,
                       input logic eb, input logic ed, input logic et,
                       input logic ee, input logic [15:0] ecnt);
    bus1.start        = st;
    bus1.target_order = tg;
    bus1.rvfi_valid   = v;
    bus1.rvfi_order   = od;
    push("u1.check", 64'(ec));
    push("u1.check_channel", 64'(ech));
    push("u1.busy", 64'(eb));
    push("u1.done", 64'(ed));
    push("u1.timed_out", 64'(et));
    push("u1.err", 64'(ee));
    push("u1.retire_count", 64'(ecnt));
    @(negedge clock);
    observe(64'(bus1.check));
    observe(64'(bus1.check_channel));
    observe(64'(bus1.busy));
    observe(64'(bus1.done));
    observe(64'(bus1.timed_out));
    observe(64'(bus1.err));
    observe(64'(bus1.retire_count));
    $display("u1 start=%0b tgt=%0d valid=%b order=%0d -> check=%0b busy=%0b done=%0b tmo=%0b err=%0b cnt=%0d",
             st, tg, v, od, bus1.check, bus1.busy, bus1.done, bus1.timed_out, bus1.err,
             bus1.retire_count);
    @(posedge clock);
    #1;
  endtask

  // One clock cycle on the dual-channel instance (reset also driven here).
  task automatic step2(input logic rst, input logic st, input logic [63:0] tg,
                       input logic [1:0] v, input logic [63:0] od0, input logic [63:0] od1,
                       input logic ec, input logic ech, input logic eb, input logic ed,
                       input logic et, input logic ee, input logic [15:0] ecnt);
    reset             = rst;
    bus2.start        = st;
    bus2.target_order = tg;
    bus2.rvfi_valid   = v;
    bus2.rvfi_order   = {od1, od0};
    push("u2.check", 64'(ec));
    push("u2.check_channel", 64'(ech));
    push("u2.busy", 64'(eb));
    push("u2.done", 64'(ed));
    push("u2.timed_out", 64'(et));
    push("u2.err", 64'(ee));
    push("u2.retire_count", 64'(ecnt));
    @(negedge clock);
    observe(64'(bus2.check));
    observe(64'(bus2.check_channel));
    observe(64'(bus2.busy));
    observe(64'(bus2.done));
    observe(64'(bus2.timed_out));
    observe(64'(bus2.err));
    observe(64'(bus2.retire_count));
    $display("u2 rst=%0b start=%0b tgt=%0d valid=%b ord0=%0d ord1=%0d -> check=%0b ch=%0d busy=%0b done=%0b err=%0b cnt=%0d",
             rst, st, tg, v, od0, od1, bus2.check, bus2.check_channel, bus2.busy,
             bus2.done, bus2.err, bus2.retire_count);
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset             = 1'b1;
    bus1.start        = 1'b0;
    bus1.target_order = '0;
    bus1.rvfi_valid   = '0;
    bus1.rvfi_order   = '0;
    bus2.start        = 1'b0;
    bus2.target_order = '0;
    bus2.rvfi_valid   = '0;
    bus2.rvfi_order   = '0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;

    // Single channel: orders 3,4,5 with target 5.
    //    st tgt  v  ord  chk ch busy done tmo err cnt
    step1(1, 5,   0, 0,   0,  0, 0,   0,   0,  0,  0);
    step1(0, 0,   1, 3,   0,  0, 1,   0,   0,  0,  0);
    step1(0, 0,   1, 4,   0,  0, 1,   0,   0,  0,  1);
    step1(0, 0,   1, 5,   1,  0, 1,   0,   0,  0,  2);
    step1(0, 0,   0, 0,   0,  0, 0,   1,   0,  0,  3);
    // Target 100 never retires: four WAIT cycles then timeout.
    step1(1, 100, 0, 0,   0,  0, 0,   1,   0,  0,  3);
    step1(0, 0,   0, 0,   0,  0, 1,   0,   0,  0,  0);
    step1(0, 0,   0, 0,   0,  0, 1,   0,   0,  0,  0);
    step1(0, 0,   0, 0,   0,  0, 1,   0,   0,  0,  0);
    step1(0, 0,   0, 0,   0,  0, 1,   0,   0,  0,  0);
    step1(0, 0,   0, 0,   0,  0, 0,   0,   1,  0,  0);
    // Re-arm from TMO; hit lands on the fourth WAIT cycle.
    step1(1, 100, 0, 0,   0,  0, 0,   0,   1,  0,  0);
    step1(0, 0,   1, 99,  0,  0, 1,   0,   0,  0,  0);
    step1(0, 0,   1, 99,  0,  0, 1,   0,   0,  0,  1);
    step1(0, 0,   1, 99,  0,  0, 1,   0,   0,  0,  2);
    step1(0, 0,   1, 100, 1,  0, 1,   0,   0,  0,  3);
    step1(0, 0,   0, 0,   0,  0, 0,   1,   0,  0,  4);

    // Dual channel: target 10 on channel 1 alongside order 11 on channel 0.
    //    rst st tgt v      od0 od1 chk ch busy done tmo err cnt
    step2(0, 1, 10, 2'b00, 0,  0,  0,  0, 0,   0,   0,  0,  0);
    step2(0, 0, 0,  2'b11, 11, 10, 1,  1, 1,   0,   0,  0,  0);
    step2(0, 0, 0,  2'b00, 0,  0,  0,  0, 0,   1,   0,  0,  2);
    // Both channels carry target 7 in the same cycle.
    step2(0, 1, 7,  2'b00, 0,  0,  0,  0, 0,   1,   0,  0,  2);
    step2(0, 0, 0,  2'b11, 7,  7,  1,  0, 1,   0,   0,  0,  0);
    step2(0, 0, 0,  2'b00, 0,  0,  0,  0, 0,   1,   0,  1,  2);
    // Start in WAIT is ignored; later repeat of target in DONE flags err.
    step2(0, 1, 3,  2'b00, 0,  0,  0,  0, 0,   1,   0,  1,  2);
    step2(0, 1, 9,  2'b01, 9,  0,  0,  0, 1,   0,   0,  0,  0);
    step2(0, 0, 0,  2'b10, 0,  3,  1,  1, 1,   0,   0,  0,  1);
    step2(0, 0, 0,  2'b01, 3,  0,  0,  0, 0,   1,   0,  0,  2);
    step2(0, 0, 0,  2'b00, 0,  0,  0,  0, 0,   1,   0,  1,  2);
    // Reset in the middle of WAIT with five retirements counted.
    step2(0, 1, 50, 2'b00, 0,  0,  0,  0, 0,   1,   0,  1,  2);
    step2(0, 0, 0,  2'b11, 1,  2,  0,  0, 1,   0,   0,  0,  0);
    step2(0, 0, 0,  2'b11, 3,  4,  0,  0, 1,   0,   0,  0,  2);
    step2(0, 0, 0,  2'b01, 5,  0,  0,  0, 1,   0,   0,  0,  4);
    step2(1, 0, 0,  2'b00, 0,  0,  0,  0, 1,   0,   0,  0,  5);
    step2(0, 0, 0,  2'b00, 0,  0,  0,  0, 0,   0,   0,  0,  0);
    // Re-arm and run the counter into saturation.
    step2(0, 1, 60000, 2'b00, 0, 0, 0, 0, 0,   0,   0,  0,  0);
    step2(0, 0, 0,  2'b11, 0,  1,  0,  0, 1,   0,   0,  0,  0);
    repeat (32766) @(posedge clock);
    #1;
    step2(0, 0, 0,  2'b11, 0,  1,  0,  0, 1,   0,   0,  0,  16'hFFFE);
    step2(0, 0, 0,  2'b11, 0,  1,  0,  0, 1,   0,   0,  0,  16'hFFFF);
    step2(0, 0, 0,  2'b11, 0,  1,  0,  0, 1,   0,   0,  0,  16'hFFFF);
    step2(0, 0, 0,  2'b01, 60000, 0, 1, 0, 1,  0,   0,  0,  16'hFFFF);
    step2(0, 0, 0,  2'b00, 0,  0,  0,  0, 0,   1,   0,  0,  16'hFFFF);

    n_checks++;
    assert (sb_q.size() == 0) else begin
      n_errors++;
      $error("FAIL sb_leftover: observed=%0d expected=0", sb_q.size());
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
